alu_operand_sequencer: RTL

//  Upstream feeder for the ALU shift/arith units.

---
 rtl/alu_seq_if.sv | 36 +++
 rtl/alu_operand_sequencer.sv | 110 +++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Operand sequencer bus: shared load bus in, registered bundle out.
// Master drives the load side, slave presents the bundle.
interface alu_seq_if #(
  parameter int ANCHO = 4,
  parameter int OPW   = 4
);
  logic [ANCHO-1:0] data_in;
  logic [OPW-1:0]   op_in;
  logic             flag_in;
  logic             load;
  logic             clear;
  logic             ready_in;
  logic [ANCHO-1:0] a_out;
  logic [ANCHO-1:0] b_out;
  logic [OPW-1:0]   op_out;
  logic             flag_out;
  logic             valid_out;
  logic             range_err;
  logic [1:0]       state_out;

  modport master (
    output data_in, op_in, flag_in,
    output load, clear, ready_in,
    input  a_out, b_out, op_out,
    input  flag_out, valid_out,
    input  range_err, state_out
  );

  modport slave (
    input  data_in, op_in, flag_in,
    input  load, clear, ready_in,
    output a_out, b_out, op_out,
    output flag_out, valid_out,
    output range_err, state_out
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Loads A, B, op/flag one per load edge from a shared bus,
// then holds the bundle until the ALU takes it.
module alu_operand_sequencer #(
  parameter int ANCHO = 4,
  parameter int OPW   = 4
) (
  input logic   clk,
  input logic   rst_n,
  alu_seq_if.slave io
);

  typedef enum logic [1:0] {
    S_A     = 2'b00,
    S_B     = 2'b01,
    S_OP    = 2'b10,
    S_ISSUE = 2'b11
  } state_t;

  localparam int unsigned W1 = ANCHO + 1;
  localparam logic [ANCHO:0] LIM = W1'(ANCHO);

  state_t           state_q, state_d;
  logic             load_q;
  logic [ANCHO-1:0] a_q, a_d;
  logic [ANCHO-1:0] b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             flag_q, flag_d;
  logic             valid_q, valid_d;
  logic             rerr_q, rerr_d;
  logic             load_edge;
  logic [ANCHO:0]   b_ext;

  assign load_edge = io.load & ~load_q;
  assign b_ext     = {1'b0, io.data_in};

  // Next state and bundle capture; clear beats load and handshake
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    flag_d  = flag_q;
    valid_d = valid_q;
    rerr_d  = rerr_q;
    if (io.clear) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      flag_d  = 1'b0;
      valid_d = 1'b0;
      rerr_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_A: if (load_edge) begin
          a_d     = io.data_in;
          state_d = S_B;
        end
        S_B: if (load_edge) begin
          b_d     = io.data_in;
          rerr_d  = (b_ext == '0) || (b_ext > LIM);
          state_d = S_OP;
        end
        S_OP: if (load_edge) begin
          op_d    = io.op_in;
          flag_d  = io.flag_in;
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
        S_ISSUE: if (valid_q && io.ready_in) begin
          valid_d = 1'b0;
          state_d = S_A;
        end
        default: state_d = S_A;
      endcase
    end
  end

  // State, edge-detect history and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      load_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      flag_q  <= 1'b0;
      valid_q <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= io.load;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      flag_q  <= flag_d;
      valid_q <= valid_d;
      rerr_q  <= rerr_d;
    end
  end

  assign io.a_out     = a_q;
  assign io.b_out     = b_q;
  assign io.op_out    = op_q;
  assign io.flag_out  = flag_q;
  assign io.valid_out = valid_q;
  assign io.range_err = rerr_q;
  assign io.state_out = state_q;

endmodule
